i2c_wb_cmd_ctrl: RTL
====================

Name: i2c_wb_cmd_ctrl

Overview:
- Wishbone master that sequences the byte-wide I2C master core through its register file.
- Initialises the prescaler and core enable after reset.
- Accepts single-byte register write/read requests and expands each into the TXR/CR/SR access sequence.
- Returns read data and a status code; sits between the system request interface and the I2C core's Wishbone slave port.

Parameters:
- PRESCALE, 16'd99, value written to PRERhi:PRERlo at init (wb_clk/(5*SCL)-1).
- POLL_LIMIT, 1024, max SR reads per byte phase before timeout abort.

Ports:
- wb_clk_i  in  1  single system clock
- wb_rst_i  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle and init complete
- req_rw  in  1  0=write, 1=read
- req_dev_addr  in  7  I2C slave address
- req_reg_addr  in  8  slave register index
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data (valid with rsp_valid when rw=1 and status=0)
- rsp_status  out  2  0=ok, 1=NACK, 2=arbitration lost, 3=timeout
- wbm_adr_o  out  3  core register address
- wbm_dat_o  out  8  write data to core
- wbm_dat_i  in  8  read data from core
- wbm_we_o  out  1  write enable
- wbm_stb_o  out  1  strobe
- wbm_cyc_o  out  1  cycle
- wbm_ack_i  in  1  slave acknowledge

Behaviour:
- Core map: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR(w)/RXR(r), 4 CR(w)/SR(r).
- CR bits: STA=7, STO=6, RD=5, WR=4, ACK=3.
- SR bits: RxACK=7, AL=5, TIP=1.
- Reset: all outputs 0; wbm_* idle; FSM enters INIT; counters cleared.
- Reset mid-operation aborts immediately, with no STOP issued, and restarts INIT.
- Bus access:
  - One access per FSM step: cyc/stb/we/adr/dat driven from a registered state, held stable until wbm_ack_i.
  - cyc/stb deassert the cycle after ack; minimum 1 idle cycle between accesses.
  - No internal Wishbone timeout.
- INIT: write PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=0x80, then IDLE.
- IDLE: req_ready=1. Accept on req_valid&req_ready, latching all req_* fields; req_ready drops the next cycle.
- Write request phases:
  - TXR={dev,0}; CR=0x90.
  - TXR=reg; CR=0x10.
  - TXR=wdata; CR=0x50.
- Read request phases:
  - TXR={dev,0}; CR=0x90.
  - TXR=reg; CR=0x10.
  - TXR={dev,1}; CR=0x90.
  - CR=0x68 (RD, NACK, STO).
  - Then read RXR into rsp_rdata.
- POLL after every CR write:
  - Read SR repeatedly until TIP=0.
  - Each read increments poll_cnt; poll_cnt clears at each CR write.
- Abort priority at SR evaluation is AL > timeout > NACK.
- AL=1 at any SR read: status 2, abort with no STOP write.
- poll_cnt reaches POLL_LIMIT with TIP still 1: status 3, write CR=0x40, no further polling.
- TIP=0 and RxACK=1 in an address/data-write phase: status 1, write CR=0x40, poll until TIP=0 (AL/timeout during that poll is ignored).
- RxACK is not checked after the read-data phase (master NACK).
- Completion:
  - rsp_valid pulses 1 cycle in DONE; rsp_status/rsp_rdata held until the next accept.
  - FSM returns to IDLE the cycle after DONE.
- req_valid during busy is ignored; no queueing.
- Latency (write, zero-wait slave, 1 poll each): 9 Wishbone accesses plus idle gaps plus DONE.

Test Plan:
- Reset release -> exactly 3 writes: adr0=0x63, adr1=0x00, adr2=0x80; then req_ready=1 (PRESCALE=99).
- Write dev=0x50, reg=0x10, data=0xA5, slave ACKs all bytes -> TXR 0xA0/0x10/0xA5 with CR 0x90/0x10/0x50; rsp_status=0; one rsp_valid pulse.
- Read dev=0x50, reg=0x22, RXR=0x3C -> TXR 0xA0, 0x22, 0xA1, CR 0x68, adr3 read; rsp_rdata=0x3C, status=0.
- NACK on address byte (SR=0x80 after the first CR) -> CR=0x40 written, polled to TIP=0, rsp_status=1; no TXR=reg write.
- AL set (SR=0x20) during the data phase -> no CR=0x40, rsp_status=2, req_ready=1 two cycles later.
- TIP stuck at 1 with POLL_LIMIT=8 -> exactly 8 SR reads, CR=0x40, rsp_status=3.
- wb_rst_i asserted mid-poll -> wbm_cyc_o=0 the next cycle, INIT sequence repeats.

Source files
------------

// File: rtl/i2c_wb_cmd_ctrl.sv
// Wishbone master that drives a byte-wide I2C master core through its register file,
// turning single-byte register read/write requests into TXR/CR/SR access sequences.
module i2c_wb_cmd_ctrl #(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;

  localparam logic [7:0] CTR_EN      = 8'h80;
  localparam logic [7:0] CR_STA_WR   = 8'h90;
  localparam logic [7:0] CR_WR       = 8'h10;
  localparam logic [7:0] CR_WR_STO   = 8'h50;
  localparam logic [7:0] CR_RD_NACK  = 8'h68;
  localparam logic [7:0] CR_STO      = 8'h40;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NACK = 2'd1;
  localparam logic [1:0] ST_AL   = 2'd2;
  localparam logic [1:0] ST_TO   = 2'd3;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_RXR, S_STOP, S_STOP_POLL, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]       status_q, status_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [2:0]       adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]       rsp_status_q, rsp_status_d;

  logic             has_acc_c;
  logic             acc_we_c;
  logic [2:0]       acc_adr_c;
  logic [7:0]       acc_dat_c;
  logic             ack_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             sr_rxack_c, sr_al_c, sr_tip_c;

  // Register access belonging to the current step.
  always_comb begin
    has_acc_c = 1'b1;
    acc_we_c  = 1'b1;
    acc_adr_c = ADR_CR;
    acc_dat_c = 8'h00;
    case (state_q)
      S_INIT: begin
        acc_adr_c = ADR_PRERLO + 3'(step_q);
        case (step_q)
          2'd0:    acc_dat_c = PRESCALE[7:0];
          2'd1:    acc_dat_c = PRESCALE[15:8];
          default: acc_dat_c = CTR_EN;
        endcase
      end
      S_TXR: begin
        acc_adr_c = ADR_TXR;
        case (step_q)
          2'd0:    acc_dat_c = {dev_q, 1'b0};
          2'd1:    acc_dat_c = reg_q;
          default: acc_dat_c = rw_q ? {dev_q, 1'b1} : wdata_q;
        endcase
      end
      S_CR: begin
        case (step_q)
          2'd0:    acc_dat_c = CR_STA_WR;
          2'd1:    acc_dat_c = CR_WR;
          2'd2:    acc_dat_c = rw_q ? CR_STA_WR : CR_WR_STO;
          default: acc_dat_c = CR_RD_NACK;
        endcase
      end
      S_POLL, S_STOP_POLL: acc_we_c = 1'b0;
      S_RXR: begin
        acc_we_c  = 1'b0;
        acc_adr_c = ADR_TXR;
      end
      S_STOP: acc_dat_c = CR_STO;
      default: has_acc_c = 1'b0;
    endcase
  end

  assign ack_c      = cyc_q & wbm_ack_i;
  assign cnt_nxt_c  = poll_cnt_q + CNT_W'(1);
  assign sr_rxack_c = wbm_dat_i[7];
  assign sr_al_c    = wbm_dat_i[5];
  assign sr_tip_c   = wbm_dat_i[1];

  // Sequencer and bus engine: launch from an idle bus, hold until ack, drop after ack.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    rw_d         = rw_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    poll_cnt_d   = poll_cnt_q;
    status_d     = status_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    if (has_acc_c) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = acc_we_c;
        adr_d = acc_adr_c;
        dat_d = acc_dat_c;
      end else if (wbm_ack_i) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        we_d  = 1'b0;
      end
    end

    case (state_q)
      S_INIT: if (ack_c) begin
        if (step_q == 2'd2) begin
          step_d  = 2'd0;
          state_d = S_IDLE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_IDLE: if (req_valid && req_ready_q) begin
        rw_d     = req_rw;
        dev_d    = req_dev_addr;
        reg_d    = req_reg_addr;
        wdata_d  = req_wdata;
        step_d   = 2'd0;
        status_d = ST_OK;
        state_d  = S_TXR;
      end
      S_TXR: if (ack_c) state_d = S_CR;
      S_CR: if (ack_c) begin
        poll_cnt_d = '0;
        state_d    = S_POLL;
      end
      S_POLL: if (ack_c) begin
        poll_cnt_d = cnt_nxt_c;
        if (sr_al_c) begin
          status_d = ST_AL;
          state_d  = S_DONE;
        end else if (sr_tip_c) begin
          if (cnt_nxt_c == CNT_W'(POLL_LIMIT)) begin
            status_d = ST_TO;
            state_d  = S_STOP;
          end
        end else if (sr_rxack_c && step_q != 2'd3) begin
          status_d = ST_NACK;
          state_d  = S_STOP;
        end else if (!rw_q && step_q == 2'd2) begin
          state_d = S_DONE;
        end else if (step_q == 2'd3) begin
          state_d = S_RXR;
        end else begin
          // The read-data phase has no TXR byte, so it goes straight to CR.
          step_d  = step_q + 2'd1;
          state_d = (rw_q && step_q == 2'd2) ? S_CR : S_TXR;
        end
      end
      S_RXR: if (ack_c) begin
        rsp_rdata_d = wbm_dat_i;
        state_d     = S_DONE;
      end
      S_STOP: if (ack_c) begin
        poll_cnt_d = '0;
        state_d    = (status_q == ST_TO) ? S_DONE : S_STOP_POLL;
      end
      S_STOP_POLL: if (ack_c) begin
        poll_cnt_d = cnt_nxt_c;
        if (!sr_tip_c) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    rsp_valid_d = (state_d == S_DONE);
    if (state_d == S_DONE) rsp_status_d = status_d;
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_INIT;
      step_q       <= '0;
      rw_q         <= 1'b0;
      dev_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      poll_cnt_q   <= '0;
      status_q     <= ST_OK;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      poll_cnt_q   <= poll_cnt_d;
      status_q     <= status_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_we_o   = we_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;

endmodule
